// File: rtl/gpio_ctrl.sv
// rtl/gpio_ctrl.sv - parametrised GPIO with output enables, synchronised and debounced inputs, edge interrupts
module gpio_ctrl #(
    parameter int DW       = 16,
    parameter int SYNC_STG = 2,
    parameter int DB_W     = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          bus_we,
    input  logic          bus_re,
    input  logic [2:0]    bus_addr,
    input  logic [DW-1:0] bus_wdata,
    output logic [DW-1:0] bus_rdata,
    input  logic [DW-1:0] gpio_in,
    output logic [DW-1:0] gpio_out,
    output logic [DW-1:0] gpio_oe,
    output logic          irq
);

    localparam logic [2:0] A_OUT     = 3'd0;
    localparam logic [2:0] A_OE      = 3'd1;
    localparam logic [2:0] A_IN      = 3'd2;
    localparam logic [2:0] A_RISE_EN = 3'd3;
    localparam logic [2:0] A_FALL_EN = 3'd4;
    localparam logic [2:0] A_IRQ     = 3'd5;
    localparam logic [2:0] A_DB_LIM  = 3'd6;
    localparam logic [2:0] A_OUT_TGL = 3'd7;

    logic [DW-1:0]                r_out;
    logic [DW-1:0]                r_oe;
    logic [DW-1:0]                r_rise_en;
    logic [DW-1:0]                r_fall_en;
    logic [DW-1:0]                r_irq_stat;
    logic [DB_W-1:0]              r_db_limit;
    logic [SYNC_STG-1:0][DW-1:0]  r_sync;
    logic [DW-1:0]                r_stable;
    logic [DW-1:0][DB_W-1:0]      r_cnt;
    logic [DW-1:0]                r_rdata;

    logic [DW-1:0]                w_sync;
    logic [DW-1:0]                w_upd;
    logic [DW-1:0]                w_set;
    logic [DW-1:0]                w_clr;
    logic [DW-1:0]                w_rd_mux;

    assign w_sync    = r_sync[SYNC_STG-1];
    assign gpio_out  = r_out;
    assign gpio_oe   = r_oe;
    assign bus_rdata = r_rdata;
    assign irq       = |r_irq_stat;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STG-2:0], gpio_in};
        end
    end

    // A bit commits when sync has disagreed with stable for DB_LIMIT+1 consecutive cycles.
    always_comb begin
        w_upd = '0;
        for (int i = 0; i < DW; i++) begin
            w_upd[i] = (w_sync[i] != r_stable[i]) && (r_cnt[i] >= r_db_limit);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stable <= '0;
            r_cnt    <= '0;
        end else begin
            for (int i = 0; i < DW; i++) begin
                if (w_sync[i] == r_stable[i]) begin
                    r_cnt[i] <= '0;
                end else if (w_upd[i]) begin
                    r_stable[i] <= w_sync[i];
                    r_cnt[i]    <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Events are qualified by the new level, so enabling never fires on a static level.
    assign w_set = w_upd & ((w_sync & r_rise_en) | (~w_sync & r_fall_en));
    assign w_clr = (bus_we && (bus_addr == A_IRQ)) ? bus_wdata : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out      <= '0;
            r_oe       <= '0;
            r_rise_en  <= '0;
            r_fall_en  <= '0;
            r_db_limit <= '0;
            r_irq_stat <= '0;
        end else begin
            r_irq_stat <= (r_irq_stat & ~w_clr) | w_set;
            if (bus_we) begin
                case (bus_addr)
                    A_OUT:     r_out      <= bus_wdata;
                    A_OE:      r_oe       <= bus_wdata;
                    A_RISE_EN: r_rise_en  <= bus_wdata;
                    A_FALL_EN: r_fall_en  <= bus_wdata;
                    A_DB_LIM:  r_db_limit <= DB_W'(bus_wdata);
                    A_OUT_TGL: r_out      <= r_out ^ bus_wdata;
                    default:   ;
                endcase
            end
        end
    end

    always_comb begin
        w_rd_mux = '0;
        case (bus_addr)
            A_OUT:     w_rd_mux = r_out;
            A_OE:      w_rd_mux = r_oe;
            A_IN:      w_rd_mux = r_stable;
            A_RISE_EN: w_rd_mux = r_rise_en;
            A_FALL_EN: w_rd_mux = r_fall_en;
            A_IRQ:     w_rd_mux = r_irq_stat;
            A_DB_LIM:  w_rd_mux = DW'(r_db_limit);
            default:   w_rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rdata <= '0;
        end else if (bus_re) begin
            r_rdata <= w_rd_mux;
        end
    end

endmodule

// File: tb/tb_gpio_ctrl.sv
// tb/tb_gpio_ctrl.sv - directed self-checking bench for gpio_ctrl
module tb_gpio_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        bus_we;
    logic        bus_re;
    logic [2:0]  bus_addr;
    logic [15:0] bus_wdata;
    logic [15:0] bus_rdata;
    logic [15:0] gpio_in;
    logic [15:0] gpio_out;
    logic [15:0] gpio_oe;
    logic        irq;

    int n_cmp = 0;
    int n_err = 0;
    logic [15:0] rd;

    gpio_ctrl #(.DW(16), .SYNC_STG(2), .DB_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus_we    (bus_we),
        .bus_re    (bus_re),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .gpio_in   (gpio_in),
        .gpio_out  (gpio_out),
        .gpio_oe   (gpio_oe),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [15:0] d);
        bus_we    = 1'b1;
        bus_addr  = a;
        bus_wdata = d;
        tick();
        bus_we    = 1'b0;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [15:0] d);
        bus_re   = 1'b1;
        bus_addr = a;
        tick();
        bus_re   = 1'b0;
        d        = bus_rdata;
    endtask

    initial begin
        rst = 1'b0; bus_we = 1'b0; bus_re = 1'b0; bus_addr = 3'd0;
        bus_wdata = 16'h0; gpio_in = 16'hFFFF;

        // reset held with pins high
        repeat (3) tick();
        chk("rst_out", gpio_out, 16'h0000);
        chk("rst_oe", gpio_oe, 16'h0000);
        chk("rst_irq", {15'b0, irq}, 16'h0000);
        chk("rst_rdata", bus_rdata, 16'h0000);
        gpio_in = 16'h0000;
        rst = 1'b1;
        repeat (4) tick();
        bus_read(3'd2, rd); chk("rst_in_read", rd, 16'h0000);
        bus_read(3'd6, rd); chk("rst_dblim", rd, 16'h0000);

        // output registers
        bus_write(3'd0, 16'hFA1C);
        chk("out_wr", gpio_out, 16'hFA1C);
        bus_write(3'd1, 16'h00FF);
        chk("oe_wr", gpio_oe, 16'h00FF);
        bus_write(3'd7, 16'h000F);
        chk("out_tgl", gpio_out, 16'hFA13);
        bus_read(3'd7, rd); chk("tgl_read0", rd, 16'h0000);
        bus_read(3'd0, rd); chk("out_read", rd, 16'hFA13);
        bus_we = 1'b1; bus_re = 1'b1; bus_addr = 3'd0; bus_wdata = 16'h1111;
        tick();
        bus_we = 1'b0; bus_re = 1'b0;
        chk("rw_same_pre", bus_rdata, 16'hFA13);
        bus_read(3'd0, rd); chk("rw_same_post", rd, 16'h1111);

        // unfiltered input: IN commits at edge t+3, visible to a read issued at t+4
        bus_write(3'd6, 16'h0000);
        gpio_in = 16'hFA1C;
        for (int k = 1; k <= 4; k++) begin
            bus_read(3'd2, rd);
            chk($sformatf("nofilt_k%0d", k), rd, (k < 4) ? 16'h0000 : 16'hFA1C);
        end
        bus_write(3'd2, 16'h1234);
        bus_read(3'd2, rd); chk("in_wr_ignored", rd, 16'hFA1C);

        // debounce limit 4, upper write bits dropped
        bus_write(3'd6, 16'hFFF4);
        bus_read(3'd6, rd); chk("dblim_read", rd, 16'h0004);
        gpio_in = 16'hFA1D;
        repeat (3) tick();
        gpio_in = 16'hFA1C;
        for (int k = 1; k <= 10; k++) begin
            bus_read(3'd2, rd);
            chk($sformatf("glitch_k%0d", k), rd, 16'hFA1C);
        end
        gpio_in = 16'hFA1D;
        for (int k = 1; k <= 8; k++) begin
            bus_read(3'd2, rd);
            chk($sformatf("held_k%0d", k), rd, (k <= 7) ? 16'hFA1C : 16'hFA1D);
        end

        // interrupts
        bus_write(3'd6, 16'h0000);
        gpio_in = 16'hFA1C;
        repeat (4) tick();
        bus_write(3'd3, 16'h0001);
        bus_write(3'd4, 16'h8000);
        chk("en_no_event_irq", {15'b0, irq}, 16'h0000);
        bus_read(3'd5, rd); chk("en_no_event_stat", rd, 16'h0000);
        gpio_in = 16'hFA1D;
        repeat (2) tick();
        chk("rise_irq_early", {15'b0, irq}, 16'h0000);
        tick();
        chk("rise_irq", {15'b0, irq}, 16'h0001);
        bus_read(3'd5, rd); chk("rise_stat", rd, 16'h0001);
        gpio_in = 16'h7A1D;
        repeat (3) tick();
        bus_read(3'd5, rd); chk("fall_stat", rd, 16'h8001);
        bus_write(3'd5, 16'h0001);
        bus_read(3'd5, rd); chk("w1c_stat", rd, 16'h8000);
        chk("w1c_irq", {15'b0, irq}, 16'h0001);
        gpio_in = 16'hFA1D;
        repeat (3) tick();
        bus_read(3'd5, rd); chk("rise15_no_en", rd, 16'h8000);
        gpio_in = 16'h7A1D;
        repeat (2) tick();
        bus_write(3'd5, 16'h8000);
        bus_read(3'd5, rd); chk("set_wins", rd, 16'h8000);

        // async reset in the middle of a debounce count
        bus_write(3'd6, 16'h0004);
        gpio_in = 16'h7A1C;
        repeat (4) tick();
        #3 rst = 1'b0;
        #1;
        chk("arst_irq", {15'b0, irq}, 16'h0000);
        chk("arst_out", gpio_out, 16'h0000);
        chk("arst_oe", gpio_oe, 16'h0000);
        chk("arst_rdata", bus_rdata, 16'h0000);
        gpio_in = 16'h0000;
        repeat (2) tick();
        rst = 1'b1;
        repeat (3) tick();
        bus_read(3'd5, rd); chk("arst_stat", rd, 16'h0000);
        bus_write(3'd6, 16'h0004);
        gpio_in = 16'h0001;
        for (int k = 1; k <= 8; k++) begin
            bus_read(3'd2, rd);
            chk($sformatf("post_rst_k%0d", k), rd, (k <= 7) ? 16'h0000 : 16'h0001);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
